// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives the 16-LED board display. An internal divider produces a one-cycle
//   tick every CLK_DIV clocks. On each tick one step of the mode selected by SW
//   is applied: hold, rotate left, rotate right, or bounce between the ends.
//
// Ports
//   clk    system clock
//   rst    synchronous, active-high reset
//   SW     mode select (asynchronous): 00 hold, 01 left, 10 right, 11 bounce
//   LED    current one-hot LED pattern
//   tick   registered one-cycle pulse marking each step boundary
//   mode   mode applied at the most recent tick
//   dir    bounce direction: 0 = toward bit 15, 1 = toward bit 0
//   steps  number of ticks that moved the pattern, modulo 256
module led_pattern_sequencer #(
  parameter logic [23:0] CLK_DIV  = 24'd10000000,
  parameter logic [15:0] LED_INIT = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  SW,
  output logic [15:0] LED,
  output logic        tick,
  output logic [1:0]  mode,
  output logic        dir,
  output logic [7:0]  steps
);

  typedef enum logic [1:0] {
    ModeHold   = 2'b00,
    ModeLeft   = 2'b01,
    ModeRight  = 2'b10,
    ModeBounce = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  logic [1:0]  sw_s1;
  logic [1:0]  sw_s2;
  logic [23:0] cnt;
  mode_e       mode_q;
  dir_e        dir_q;

  assign mode = mode_q;
  assign dir  = dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= 2'b00;
      sw_s2  <= 2'b00;
      cnt    <= '0;
      tick   <= 1'b0;
      LED    <= LED_INIT;
      mode_q <= ModeHold;
      dir_q  <= DirUp;
      steps  <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;

      if (cnt == CLK_DIV - 24'd1) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 24'd1;
        tick <= 1'b0;
      end

      // The step lands on the edge closing the tick-high cycle, so outputs
      // change one cycle after tick is seen.
      if (tick) begin
        mode_q <= mode_e'(sw_s2);
        unique case (mode_e'(sw_s2))
          ModeHold: ;
          ModeLeft: begin
            LED   <= {LED[14:0], LED[15]};
            steps <= steps + 8'd1;
          end
          ModeRight: begin
            LED   <= {LED[0], LED[15:1]};
            steps <= steps + 8'd1;
          end
          ModeBounce: begin
            steps <= steps + 8'd1;
            // Reversing at an end moves straight off it, so an end lamp is
            // never shown on two consecutive steps.
            if (dir_q == DirUp) begin
              if (LED[15]) begin
                dir_q <= DirDown;
                LED   <= LED >> 1;
              end else begin
                LED   <= LED << 1;
              end
            end else begin
              if (LED[0]) begin
                dir_q <= DirUp;
                LED   <= LED << 1;
              end else begin
                LED   <= LED >> 1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
